// File: rtl/proc_io_pkg.sv
// Shared types and defaults for the Processor word-stream I/O bridge.
package proc_io_pkg;

    localparam int WORD_W        = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_GAP   = 3;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE,
        PULSE
    } dlv_state_t;

endpackage

// File: rtl/proc_io_bridge_if.sv
// Host stream and Processor strobe signals of the bridge; slave is the bridge's view.
interface proc_io_bridge_if;
    import proc_io_pkg::*;

    logic  host_in_valid;
    word_t host_in_data;
    logic  host_in_ready;
    logic  host_out_valid;
    word_t host_out_data;
    logic  host_out_ready;
    logic  proc_iEn;
    word_t proc_PIn;
    logic  proc_oEn;
    word_t proc_POut;

    modport slave (
        input  host_in_valid, host_in_data, host_out_ready, proc_oEn, proc_POut,
        output host_in_ready, host_out_valid, host_out_data, proc_iEn, proc_PIn
    );

    modport master (
        output host_in_valid, host_in_data, host_out_ready, proc_oEn, proc_POut,
        input  host_in_ready, host_out_valid, host_out_data, proc_iEn, proc_PIn
    );

endinterface

// File: rtl/proc_io_fifo.sv
// Synchronous word FIFO; a push into a full FIFO lands only if a pop frees a slot that same cycle.
module proc_io_fifo
    import proc_io_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  word_t din,
    output word_t dout,
    output logic  empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so the output port shows a clean value after reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/proc_io_bridge.sv
// Host <-> Processor word bridge: paced iEn/PIn delivery from an input FIFO, oEn/POut capture into an output FIFO.
module proc_io_bridge
    import proc_io_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic            system1000,
    input  logic            system1000_rst,
    proc_io_bridge_if.slave io,
    output logic            overflow,
    input  logic            clr_overflow
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    dlv_state_t    state;
    dlv_state_t    state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;
    logic          dlv_pop;
    word_t         pin_q;

    logic          in_empty;
    logic          in_full;
    word_t         in_head;
    logic          in_push;

    logic          out_empty;
    logic          out_full;
    logic          out_pop;
    logic          out_drop;

    assign in_push          = io.host_in_valid && !in_full;
    assign io.host_in_ready = !in_full;

    proc_io_fifo #(.DEPTH(DEPTH)) u_in_fifo (
        .clk   (system1000),
        .rst   (system1000_rst),
        .push  (in_push),
        .pop   (dlv_pop),
        .din   (io.host_in_data),
        .dout  (in_head),
        .empty (in_empty),
        .full  (in_full)
    );

    // gap_cnt is loaded as the pulse issues and counts down through the pulse cycle,
    // so the next pulse can land exactly GAP+1 cycles after the previous one.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        dlv_pop   = 1'b0;
        if (gap_cnt != '0) gap_nxt = gap_cnt - 1'b1;
        case (state)
            IDLE: begin
                if (!in_empty && gap_cnt == '0) begin
                    state_nxt = PULSE;
                    dlv_pop   = 1'b1;
                    gap_nxt   = GW'(GAP);
                end
            end
            PULSE: begin
                if (GAP == 0 && !in_empty) begin
                    state_nxt = PULSE;
                    dlv_pop   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            pin_q   <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (dlv_pop) pin_q <= in_head;
        end
    end

    // Every PULSE cycle is exactly one delivered word, so iEn decodes straight from the state flop.
    assign io.proc_iEn = (state == PULSE);
    assign io.proc_PIn = pin_q;

    assign out_pop           = !out_empty && io.host_out_ready;
    assign out_drop          = io.proc_oEn && out_full && !out_pop;
    assign io.host_out_valid = !out_empty;

    proc_io_fifo #(.DEPTH(DEPTH)) u_out_fifo (
        .clk   (system1000),
        .rst   (system1000_rst),
        .push  (io.proc_oEn),
        .pop   (out_pop),
        .din   (io.proc_POut),
        .dout  (io.host_out_data),
        .empty (out_empty),
        .full  (out_full)
    );

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            overflow <= 1'b0;
        end else if (out_drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed bench for proc_io_bridge (DEPTH=4, GAP=3) with hand-computed expectations.
module tb_proc_io_bridge;
    import proc_io_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;
    logic clr_overflow = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    word_t pulse_q[$];
    int    pulse_cyc[$];

    proc_io_bridge_if bus ();

    proc_io_bridge #(.DEPTH(4), .GAP(3)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .io             (bus.slave),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.proc_iEn === 1'b1) begin
            pulse_q.push_back(bus.proc_PIn);
            pulse_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [31:0] pin_at(input int i);
        if (i < pulse_q.size()) return 32'(pulse_q[i]);
        return 'x;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < pulse_cyc.size()) return pulse_cyc[i];
        return -1;
    endfunction

    initial begin
        int    t0;
        int    k;
        logic  rdy;
        bit    exp_rdy[7] = '{1, 1, 1, 1, 1, 0, 1};
        word_t burst_d[3] = '{16'sd100, -16'sd1, 16'sd32767};
        word_t fill_d[6] = '{16'sd1000, -16'sd2000, 16'sd0, -16'sd32768, 16'sd7, 16'sd12345};
        word_t ovf_d[5] = '{16'sd11, -16'sd12, 16'sd13, 16'sd14, 16'sd15};
        word_t drain_d[4];

        bus.host_in_valid  = 1'b0;
        bus.host_in_data   = '0;
        bus.host_out_ready = 1'b0;
        bus.proc_oEn       = 1'b0;
        bus.proc_POut      = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and quiet idle
        for (int i = 0; i < 10; i++) begin
            check("idle_iEn", bus.proc_iEn, 0);
            step();
        end
        check("rst_PIn", bus.proc_PIn, 0);
        check("rst_out_valid", bus.host_out_valid, 0);
        check("rst_out_data", bus.host_out_data, 0);
        check("rst_in_ready", bus.host_in_ready, 1);
        check("rst_overflow", overflow, 0);
        check("idle_no_pulse", pulse_q.size(), 0);

        // Three back-to-back host words, GAP=3: pulses at +2, +6, +10
        pulse_q.delete();
        pulse_cyc.delete();
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            bus.host_in_valid = 1'b1;
            bus.host_in_data  = burst_d[i];
            step();
        end
        bus.host_in_valid = 1'b0;
        repeat (12) step();
        check("burst_npulse", pulse_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("burst_when", cyc_at(i) - t0, 2 + 4 * i);
            check("burst_data", pin_at(i), burst_d[i]);
        end
        check("PIn_hold", bus.proc_PIn, 32767);

        // Continuous offer: first word goes to delivery, next DEPTH fill the FIFO
        pulse_q.delete();
        pulse_cyc.delete();
        t0 = cyc;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            check("fill_ready", bus.host_in_ready, exp_rdy[i]);
            rdy = bus.host_in_ready;
            bus.host_in_valid = 1'b1;
            bus.host_in_data  = fill_d[k];
            step();
            if (rdy) k++;
        end
        bus.host_in_valid = 1'b0;
        check("fill_accepts", k, 6);
        repeat (18) step();
        check("fill_npulse", pulse_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("fill_when", cyc_at(i) - t0, 2 + 4 * i);
            check("fill_data", pin_at(i), fill_d[i]);
        end

        // Processor emits -5, 7 with host always ready
        bus.host_out_ready = 1'b1;
        bus.proc_oEn  = 1'b1;
        bus.proc_POut = -16'sd5;
        check("cap_pre_valid", bus.host_out_valid, 0);
        step();
        check("cap_valid0", bus.host_out_valid, 1);
        check("cap_data0", bus.host_out_data, -5);
        bus.proc_POut = 16'sd7;
        step();
        bus.proc_oEn = 1'b0;
        check("cap_valid1", bus.host_out_valid, 1);
        check("cap_data1", bus.host_out_data, 7);
        step();
        check("cap_empty", bus.host_out_valid, 0);
        check("cap_no_ovf", overflow, 0);

        // Host stalled, DEPTH+1 Processor words: last one dropped
        bus.host_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ovf_pre", overflow, 0);
            bus.proc_oEn  = 1'b1;
            bus.proc_POut = ovf_d[i];
            step();
        end
        bus.proc_oEn = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_valid", bus.host_out_valid, 1);
        check("ovf_head", bus.host_out_data, ovf_d[0]);
        repeat (2) step();
        check("ovf_sticky", overflow, 1);
        check("ovf_head_stable", bus.host_out_data, ovf_d[0]);

        // New drop and clear in the same cycle: set wins
        bus.proc_oEn  = 1'b1;
        bus.proc_POut = 16'sd99;
        clr_overflow  = 1'b1;
        step();
        bus.proc_oEn = 1'b0;
        clr_overflow = 1'b0;
        check("ovf_set_wins", overflow, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO, push and pop together: no drop
        bus.proc_oEn       = 1'b1;
        bus.proc_POut      = 16'sd55;
        bus.host_out_ready = 1'b1;
        step();
        bus.proc_oEn = 1'b0;
        check("pp_no_ovf", overflow, 0);
        drain_d[0] = ovf_d[1];
        drain_d[1] = ovf_d[2];
        drain_d[2] = ovf_d[3];
        drain_d[3] = 16'sd55;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", bus.host_out_valid, 1);
            check("drain_data", bus.host_out_data, drain_d[i]);
            step();
        end
        check("drain_empty", bus.host_out_valid, 0);
        bus.host_out_ready = 1'b0;

        // Reset during a pulse with two words still queued
        pulse_q.delete();
        pulse_cyc.delete();
        bus.proc_oEn  = 1'b1;
        bus.proc_POut = 16'sd77;
        for (int i = 0; i < 4; i++) begin
            bus.host_in_valid = 1'b1;
            bus.host_in_data  = word_t'(5 + i);
            step();
            bus.proc_oEn = 1'b0;
        end
        bus.host_in_valid = 1'b0;
        repeat (2) step();
        check("pre_rst_iEn", bus.proc_iEn, 1);
        check("pre_rst_PIn", bus.proc_PIn, 6);
        check("pre_rst_out_valid", bus.host_out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_iEn", bus.proc_iEn, 0);
        check("rst_async_PIn", bus.proc_PIn, 0);
        check("rst_async_out_valid", bus.host_out_valid, 0);
        check("rst_async_in_ready", bus.host_in_ready, 1);
        step();
        rst = 1'b0;
        repeat (12) step();
        check("post_rst_npulse", pulse_q.size(), 1);
        check("post_rst_first", pin_at(0), 5);
        check("post_rst_iEn", bus.proc_iEn, 0);
        check("post_rst_out_valid", bus.host_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
